mc_ctrl: RTL

- Multi-cycle main controller for the MIPS datapath: sequences PC, IR, GRF, DM, ALU, NPC and the immediate extender through per-instruction state paths.
- Drives the extender's ExtOp select and all datapath mux selects and write enables.
- Counts retired instructions.
- Sits beside the datapath top; inputs come from IR fields and the ALU zero flag.

---
 rtl/mc_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// A six-state FSM steps each instruction through FETCH/DECODE/EXE/MEM/WB.
// Control outputs are decoded combinationally from state, op and funct.
// Every write enable and the illegal pulse are held low while reset is low.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             PCWr,
   output logic             IRWr,
   output logic             RegWr,
   output logic             MemWr,
   output logic             ExtOp,
   output logic             ALUSrc,
   output logic [2:0]       ALUOp,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       NPCOp,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM_RD = 3'd3,
      S_MEM_WR = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_JR    = 6'h08;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;

   logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
   logic w_legal;
   logic w_pcwr, w_irwr, w_regwr, w_memwr, w_illegal, w_retire;

   // Instruction decode from the IR fields
   assign w_rtype = (op == OP_R);
   assign w_addu  = w_rtype && (funct == F_ADDU);
   assign w_subu  = w_rtype && (funct == F_SUBU);
   assign w_jr    = w_rtype && (funct == F_JR);
   assign w_ori   = (op == OP_ORI);
   assign w_lui   = (op == OP_LUI);
   assign w_lw    = (op == OP_LW);
   assign w_sw    = (op == OP_SW);
   assign w_beq   = (op == OP_BEQ);
   assign w_j     = (op == OP_J);
   assign w_jal   = (op == OP_JAL);
   assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw |
                    w_beq | w_j | w_jal;

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Retired-instruction counter, wraps silently
   always_ff @(posedge clk) begin
      if (!reset)        r_cnt <= '0;
      else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
   end

   // Next-state and control decode; everything defaults to 0 / FETCH
   always_comb begin
      w_next    = S_FETCH;
      w_pcwr    = 1'b0;
      w_irwr    = 1'b0;
      w_regwr   = 1'b0;
      w_memwr   = 1'b0;
      w_illegal = 1'b0;
      w_retire  = 1'b0;
      ExtOp     = 1'b0;
      ALUSrc    = 1'b0;
      ALUOp     = 3'd0;
      RegDst    = 2'd0;
      MemtoReg  = 2'd0;
      NPCOp     = 2'd0;
      case (r_state)
         S_FETCH: begin
            w_irwr = 1'b1;
            w_pcwr = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            if (!w_legal) begin
               w_illegal = 1'b1;
            end else if (w_j || w_jal) begin
               w_pcwr   = 1'b1;
               NPCOp    = 2'd2;
               w_retire = 1'b1;
               if (w_jal) begin
                  // link: $31 <= PC, which already holds PC+4
                  w_regwr  = 1'b1;
                  RegDst   = 2'd2;
                  MemtoReg = 2'd2;
               end
            end else if (w_jr) begin
               w_pcwr   = 1'b1;
               NPCOp    = 2'd3;
               w_retire = 1'b1;
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            if (w_addu || w_subu) begin
               ALUOp  = w_subu ? 3'd1 : 3'd0;
               w_next = S_WB;
            end else if (w_ori) begin
               ExtOp  = 1'b1;
               ALUSrc = 1'b1;
               ALUOp  = 3'd2;
               w_next = S_WB;
            end else if (w_lui) begin
               ALUSrc = 1'b1;
               ALUOp  = 3'd3;
               w_next = S_WB;
            end else if (w_lw || w_sw) begin
               ALUSrc = 1'b1;
               w_next = w_lw ? S_MEM_RD : S_MEM_WR;
            end else if (w_beq) begin
               ALUOp    = 3'd1;
               NPCOp    = 2'd1;
               w_pcwr   = zero;
               w_retire = 1'b1;
            end
         end
         S_MEM_RD: begin
            // keep the address selects stable while DM is read
            ALUSrc = 1'b1;
            w_next = S_WB;
         end
         S_MEM_WR: begin
            ALUSrc   = 1'b1;
            w_memwr  = 1'b1;
            w_retire = 1'b1;
         end
         S_WB: begin
            w_regwr  = 1'b1;
            w_retire = 1'b1;
            if (w_rtype) RegDst   = 2'd1;
            if (w_lw)    MemtoReg = 2'd1;
         end
         default: ; // unreachable encodings fall back to FETCH with no writes
      endcase
   end

   assign PCWr      = w_pcwr & reset;
   assign IRWr      = w_irwr & reset;
   assign RegWr     = w_regwr & reset;
   assign MemWr     = w_memwr & reset;
   assign illegal   = w_illegal & reset;
   assign state     = r_state;
   assign instr_cnt = r_cnt;

endmodule
